// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared constants, issue-slot payload type and hazard helper for the
// dual-issue scoreboard slice.
package dual_issue_scoreboard_pkg;

   localparam int unsigned NREG  = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned LAT_W = 3;
   localparam int unsigned CNT_W = 32;

   // One decoded instruction slot as presented by decode.
   typedef struct packed {
      logic             valid;
      logic [AW-1:0]    rs1;
      logic [AW-1:0]    rs2;
      logic [AW-1:0]    rd;
      logic             wr;
      logic [LAT_W-1:0] lat;
   } slot_t;

   // A register operand conflicts only if it is nonzero and still in flight.
   function automatic logic hazard(input logic [AW-1:0]   addr,
                                   input logic [NREG-1:0] busy);
      return (addr != '0) && busy[addr];
   endfunction

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decode/writeback-side bus of the dual-issue scoreboard.
//   master : decode + pipeline side (drives the instruction pair, flush, wb)
//   slave  : scoreboard side (drives issue/stall, gated rf enables, busy,
//            performance counters)
interface dual_issue_scoreboard_if;
   import dual_issue_scoreboard_pkg::*;

   logic             flush;
   logic             top_valid;
   logic [AW-1:0]    top_rs1;
   logic [AW-1:0]    top_rs2;
   logic [AW-1:0]    top_rd;
   logic             top_wr;
   logic [LAT_W-1:0] top_lat;
   logic             bot_valid;
   logic [AW-1:0]    bot_rs1;
   logic [AW-1:0]    bot_rs2;
   logic [AW-1:0]    bot_rd;
   logic             bot_wr;
   logic [LAT_W-1:0] bot_lat;
   logic             wb_we_top;
   logic             wb_we_bot;
   logic [AW-1:0]    wb_wa_top;
   logic [AW-1:0]    wb_wa_bot;

   logic             issue_top;
   logic             issue_bot;
   logic             stall;
   logic             rf_we_top;
   logic             rf_we_bot;
   logic [NREG-1:0]  busy;
   logic [CNT_W-1:0] dual_cnt;
   logic [CNT_W-1:0] single_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output flush,
      output top_valid, top_rs1, top_rs2, top_rd, top_wr, top_lat,
      output bot_valid, bot_rs1, bot_rs2, bot_rd, bot_wr, bot_lat,
      output wb_we_top, wb_we_bot, wb_wa_top, wb_wa_bot,
      input  issue_top, issue_bot, stall, rf_we_top, rf_we_bot,
      input  busy, dual_cnt, single_cnt, stall_cnt
   );

   modport slave (
      input  flush,
      input  top_valid, top_rs1, top_rs2, top_rd, top_wr, top_lat,
      input  bot_valid, bot_rs1, bot_rs2, bot_rd, bot_wr, bot_lat,
      input  wb_we_top, wb_we_bot, wb_wa_top, wb_wa_bot,
      output issue_top, issue_bot, stall, rf_we_top, rf_we_bot,
      output busy, dual_cnt, single_cnt, stall_cnt
   );

endinterface

// File: rtl/dual_issue_scoreboard_sb_counter.sv
// Per-register in-flight countdown. A load sets the remaining latency;
// otherwise a nonzero count decrements each cycle. Busy while nonzero.
//   clk, rst : clock, async active-high reset
//   i_load   : an issuing instruction targets this register with lat > 0
//   i_lat    : latency to load
//   o_busy   : register result not yet readable
module dual_issue_scoreboard_sb_counter
   import dual_issue_scoreboard_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   output logic             o_busy
);

   logic [LAT_W-1:0] r_count;

   // Load wins over decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (i_load)
         r_count <= i_lat;
      else if (r_count != '0)
         r_count <= r_count - LAT_W'(1);
   end

   assign o_busy = (r_count != '0);

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Issue controller for the dual-ported register file. Decides which of an
// in-order (top older, bot younger) pair may issue, tracks multi-cycle
// destination writes, arbitrates same-address writebacks and counts
// dual/single/stall cycles.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of dual_issue_scoreboard_if (instruction pair,
//              flush, writeback enables in; issue/stall, gated rf enables,
//              busy vector, performance counters out)
module dual_issue_scoreboard
   import dual_issue_scoreboard_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   dual_issue_scoreboard_if.slave bus
);

   slot_t            w_top;
   slot_t            w_bot;
   logic [NREG-1:0]  w_busy;
   logic             w_top_ok;
   logic             w_bot_ok;
   logic             w_raw;
   logic             w_waw;
   logic             w_issue_top;
   logic             w_issue_bot;
   logic             w_stall;
   logic [CNT_W-1:0] r_dual_cnt;
   logic [CNT_W-1:0] r_single_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_top = '{valid: bus.top_valid, rs1: bus.top_rs1, rs2: bus.top_rs2,
                    rd: bus.top_rd, wr: bus.top_wr, lat: bus.top_lat};
   assign w_bot = '{valid: bus.bot_valid, rs1: bus.bot_rs1, rs2: bus.bot_rs2,
                    rd: bus.bot_rd, wr: bus.bot_wr, lat: bus.bot_lat};

   // Issue decision: per-slot scoreboard hazards plus intra-pair RAW/WAW.
   always_comb begin
      w_top_ok    = 1'b0;
      w_bot_ok    = 1'b0;
      w_raw       = 1'b0;
      w_waw       = 1'b0;
      w_issue_top = 1'b0;
      w_issue_bot = 1'b0;
      w_stall     = 1'b0;

      w_top_ok = w_top.valid
               & !hazard(w_top.rs1, w_busy)
               & !hazard(w_top.rs2, w_busy)
               & !(w_top.wr & hazard(w_top.rd, w_busy));
      w_bot_ok = w_bot.valid
               & !hazard(w_bot.rs1, w_busy)
               & !hazard(w_bot.rs2, w_busy)
               & !(w_bot.wr & hazard(w_bot.rd, w_busy));
      // r0 results are discarded, so a top write to r0 never feeds bot.
      w_raw = w_top.wr & (w_top.rd != '0)
            & ((w_bot.rs1 == w_top.rd) | (w_bot.rs2 == w_top.rd));
      w_waw = w_top.wr & w_bot.wr & (w_top.rd != '0) & (w_bot.rd == w_top.rd);

      w_issue_top = !rst & !bus.flush & w_top_ok;
      // Bot only ever issues alongside top to keep program order.
      w_issue_bot = w_issue_top & w_bot_ok & !w_raw & !w_waw;
      w_stall     = !rst & !bus.flush & w_top.valid & !w_issue_top;
   end

   // Per-register countdowns; r0 is hardwired not busy.
   assign w_busy[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_sb
      logic             w_ld_top;
      logic             w_ld_bot;
      logic [LAT_W-1:0] w_ld_lat;

      assign w_ld_top = w_issue_top & w_top.wr & (w_top.rd == AW'(r))
                      & (w_top.lat != '0);
      assign w_ld_bot = w_issue_bot & w_bot.wr & (w_bot.rd == AW'(r))
                      & (w_bot.lat != '0);
      // Intra-pair WAW blocking means at most one slot loads a given r.
      assign w_ld_lat = w_ld_top ? w_top.lat : w_bot.lat;

      dual_issue_scoreboard_sb_counter u_cnt (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_ld_top | w_ld_bot),
         .i_lat  (w_ld_lat),
         .o_busy (w_busy[r])
      );
   end

   // Performance counters, free-running with natural wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dual_cnt   <= '0;
         r_single_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_issue_top & w_issue_bot)
            r_dual_cnt <= r_dual_cnt + CNT_W'(1);
         if (w_issue_top & !w_issue_bot)
            r_single_cnt <= r_single_cnt + CNT_W'(1);
         if (w_stall)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.issue_top  = w_issue_top;
   assign bus.issue_bot  = w_issue_bot;
   assign bus.stall      = w_stall;
   // Younger (bot) writeback wins a same-address collision.
   assign bus.rf_we_bot  = bus.wb_we_bot & !rst;
   assign bus.rf_we_top  = bus.wb_we_top & !rst
                         & !(bus.wb_we_bot & (bus.wb_wa_bot == bus.wb_wa_top));
   assign bus.busy       = w_busy;
   assign bus.dual_cnt   = r_dual_cnt;
   assign bus.single_cnt = r_single_cnt;
   assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Scoreboard bench: a driver applies one instruction pair per cycle, evaluates
// a reference model of the issue rules and queues the expected outputs; a
// monitor on the falling edge pops and compares.
module tb_dual_issue_scoreboard;
   import dual_issue_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dual_issue_scoreboard_if bus ();

   dual_issue_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          it, ib, st, wt, wb;
      logic [31:0] busy, dual, single, stallc;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference model state: remaining busy cycles per register + counters.
   int          remain[32];
   logic [31:0] m_dual = '0, m_single = '0, m_stall = '0;
   bit          p_rst = 1'b1, p_it = 1'b0, p_ib = 1'b0, p_st = 1'b0;
   slot_t       p_t = '0, p_b = '0;

   function automatic slot_t mk(input bit v, input int s1, input int s2,
                                input int d, input bit w, input int l);
      slot_t s;
      s.valid = v;
      s.rs1   = 5'(s1);
      s.rs2   = 5'(s2);
      s.rd    = 5'(d);
      s.wr    = w;
      s.lat   = 3'(l);
      return s;
   endfunction

   function automatic bit mbusy(input logic [4:0] r);
      return (r != 0) && (remain[r] > 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // One cycle of stimulus plus its expected response.
   task automatic step(input slot_t t, input slot_t b, input bit fl, input bit rs,
                       input bit wet, input bit web, input int wat, input int wab);
      exp_t e;
      @(posedge clk);
      #1;
      if (!p_rst) begin
         for (int r = 1; r < 32; r++) begin
            if (p_it && p_t.wr && p_t.rd == 5'(r) && p_t.lat != 0)      remain[r] = int'(p_t.lat);
            else if (p_ib && p_b.wr && p_b.rd == 5'(r) && p_b.lat != 0) remain[r] = int'(p_b.lat);
            else if (remain[r] > 0)                                    remain[r]--;
         end
         if (p_it && p_ib)  m_dual++;
         if (p_it && !p_ib) m_single++;
         if (p_st)          m_stall++;
      end
      rst = rs;
      bus.flush = fl;
      bus.top_valid = t.valid; bus.top_rs1 = t.rs1; bus.top_rs2 = t.rs2;
      bus.top_rd = t.rd; bus.top_wr = t.wr; bus.top_lat = t.lat;
      bus.bot_valid = b.valid; bus.bot_rs1 = b.rs1; bus.bot_rs2 = b.rs2;
      bus.bot_rd = b.rd; bus.bot_wr = b.wr; bus.bot_lat = b.lat;
      bus.wb_we_top = wet; bus.wb_we_bot = web;
      bus.wb_wa_top = 5'(wat); bus.wb_wa_bot = 5'(wab);
      if (rs) begin
         foreach (remain[i]) remain[i] = 0;
         m_dual = '0; m_single = '0; m_stall = '0;
      end
      e.it = !rs && !fl && t.valid && !mbusy(t.rs1) && !mbusy(t.rs2)
             && !(t.wr && mbusy(t.rd));
      e.ib = e.it && b.valid && !mbusy(b.rs1) && !mbusy(b.rs2)
             && !(b.wr && mbusy(b.rd))
             && !(t.wr && t.rd != 0 && (b.rs1 == t.rd || b.rs2 == t.rd))
             && !(t.wr && b.wr && t.rd != 0 && b.rd == t.rd);
      e.st = !rs && !fl && t.valid && !e.it;
      e.wb = web && !rs;
      e.wt = wet && !rs && !(web && wat == wab);
      e.busy = '0;
      for (int r = 1; r < 32; r++) e.busy[r] = (remain[r] > 0);
      e.dual = m_dual; e.single = m_single; e.stallc = m_stall;
      q.push_back(e);
      p_rst = rs; p_it = e.it; p_ib = e.ib; p_st = e.st; p_t = t; p_b = b;
   endtask

   task automatic step_s(input slot_t t, input slot_t b);
      step(t, b, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("issue_top",  32'(bus.issue_top),  32'(e.it));
            chk("issue_bot",  32'(bus.issue_bot),  32'(e.ib));
            chk("stall",      32'(bus.stall),      32'(e.st));
            chk("rf_we_top",  32'(bus.rf_we_top),  32'(e.wt));
            chk("rf_we_bot",  32'(bus.rf_we_bot),  32'(e.wb));
            chk("busy",       bus.busy,            e.busy);
            chk("dual_cnt",   bus.dual_cnt,        e.dual);
            chk("single_cnt", bus.single_cnt,      e.single);
            chk("stall_cnt",  bus.stall_cnt,       e.stallc);
         end
      end
   end

   function automatic int rreg();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                         : int'($urandom_range(0, 7));
   endfunction

   function automatic int rlat();
      return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
   endfunction

   initial begin
      slot_t nop, pa, pb;
      logic [31:0] bz;
      foreach (remain[i]) remain[i] = 0;
      nop = '0;
      pa  = mk(1, 20, 21, 22, 1, 0);
      pb  = mk(1, 23, 24, 25, 1, 0);
      bus.flush = 0; bus.top_valid = 0; bus.top_rs1 = 0; bus.top_rs2 = 0;
      bus.top_rd = 0; bus.top_wr = 0; bus.top_lat = 0; bus.bot_valid = 0;
      bus.bot_rs1 = 0; bus.bot_rs2 = 0; bus.bot_rd = 0; bus.bot_wr = 0;
      bus.bot_lat = 0; bus.wb_we_top = 0; bus.wb_we_bot = 0;
      bus.wb_wa_top = 0; bus.wb_wa_bot = 0;

      step(nop, nop, 0, 1, 0, 0, 0, 0);
      step(nop, nop, 0, 1, 0, 0, 0, 0);

      // Independent pair, writeback collision on r12.
      step(mk(1, 2, 3, 1, 1, 0), mk(1, 5, 6, 4, 1, 0), 0, 0, 1, 1, 12, 12);
      @(negedge clk);
      chk("d_pair_top", 32'(bus.issue_top), 1);
      chk("d_pair_bot", 32'(bus.issue_bot), 1);
      chk("d_coll_top", 32'(bus.rf_we_top), 0);
      chk("d_coll_bot", 32'(bus.rf_we_bot), 1);
      // Intra-pair RAW, distinct writeback addresses.
      step(mk(1, 1, 2, 7, 1, 0), mk(1, 7, 3, 8, 1, 0), 0, 0, 1, 1, 12, 13);
      @(negedge clk);
      chk("d_raw_bot", 32'(bus.issue_bot), 0);
      chk("d_dual1",   bus.dual_cnt, 1);
      chk("d_nocoll",  32'(bus.rf_we_top), 1);
      // Load with latency 3 then dependent reader.
      step_s(mk(1, 0, 0, 9, 1, 3), nop);
      @(negedge clk);
      chk("d_single1", bus.single_cnt, 1);
      for (int i = 0; i < 3; i++) begin
         step_s(mk(1, 9, 0, 10, 1, 0), nop);
         @(negedge clk);
         chk("d_lat_stall", 32'(bus.stall), 1);
         bz = bus.busy;
         chk("d_lat_busy9", 32'(bz[9]), 1);
      end
      step_s(mk(1, 9, 0, 10, 1, 0), nop);
      @(negedge clk);
      bz = bus.busy;
      chk("d_lat_issue", 32'(bus.issue_top), 1);
      chk("d_stall_cnt", bus.stall_cnt, 3);
      chk("d_lat_free9", 32'(bz[9]), 0);
      // Top writing r0 must not block a bot reading r0.
      step_s(mk(1, 1, 2, 0, 1, 0), mk(1, 0, 0, 11, 1, 0));
      @(negedge clk);
      chk("d_r0_bot", 32'(bus.issue_bot), 1);
      // Flush while r4 counts down from 2.
      step_s(mk(1, 0, 0, 4, 1, 2), nop);
      step(pa, pb, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      bz = bus.busy;
      chk("d_fl_issue", 32'(bus.issue_top), 0);
      chk("d_fl_stall", 32'(bus.stall), 0);
      chk("d_fl_busy4", 32'(bz[4]), 1);
      step_s(nop, nop);
      @(negedge clk);
      bz = bus.busy;
      chk("d_fl_busy4b", 32'(bz[4]), 1);
      chk("d_fl_scnt",   bus.stall_cnt, 3);
      step_s(nop, nop);
      @(negedge clk);
      bz = bus.busy;
      chk("d_fl_clear4", 32'(bz[4]), 0);
      // Build dual_cnt = 7 and busy[5], then reset mid-run.
      for (int i = 0; i < 5; i++) step_s(pa, pb);
      step_s(mk(1, 0, 0, 5, 1, 4), nop);
      step_s(nop, nop);
      @(negedge clk);
      bz = bus.busy;
      chk("d_pre_dual7", bus.dual_cnt, 7);
      chk("d_pre_busy5", 32'(bz[5]), 1);
      step(pa, pb, 0, 1, 1, 1, 3, 4);
      @(negedge clk);
      chk("d_rst_busy",  bus.busy, 0);
      chk("d_rst_dual",  bus.dual_cnt, 0);
      chk("d_rst_issue", 32'(bus.issue_top), 0);
      chk("d_rst_we",    32'(bus.rf_we_bot), 0);
      step_s(pa, pb);
      @(negedge clk);
      chk("d_post_rst", 32'(bus.issue_bot), 1);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         step(mk($urandom_range(0, 7) != 0, rreg(), rreg(), rreg(),
                 $urandom_range(0, 3) != 0, rlat()),
              mk($urandom_range(0, 3) != 0, rreg(), rreg(), rreg(),
                 $urandom_range(0, 3) != 0, rlat()),
              $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dual_issue_scoreboard.md
Name: dual_issue_scoreboard

Overview:
- Issue controller for the dual-ported (top/bot) 32-entry register file.
- Each cycle it takes an in-order instruction pair (top = older, bot = younger) from decode and decides which of them may issue.
- Tracks in-flight multi-cycle destination writes in a per-register countdown scoreboard.
- Resolves same-address collisions between the two register-file write ports and keeps issue/stall performance counters.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width.
- LAT_W, 3, width of the latency field and of each per-register countdown.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash the current pair; nothing issues this cycle.
- top_valid  in  1  top slot holds an instruction.
- top_rs1, top_rs2  in  AW  top source registers.
- top_rd  in  AW  top destination register.
- top_wr  in  1  top writes top_rd.
- top_lat  in  LAT_W  cycles until top's result is readable (0 = bypassed, never busy).
- bot_valid, bot_rs1, bot_rs2, bot_rd, bot_wr, bot_lat  in  as top  younger slot.
- wb_we_top, wb_we_bot  in  1  raw writeback enables from the pipeline.
- wb_wa_top, wb_wa_bot  in  AW  writeback addresses.
- issue_top  out  1  top slot issues this cycle.
- issue_bot  out  1  bot slot issues this cycle.
- stall  out  1  top_valid & !issue_top & !flush.
- rf_we_top, rf_we_bot  out  1  gated write enables to the register file.
- busy  out  NREG  per-register busy vector, bit 0 tied 0.
- dual_cnt, single_cnt, stall_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (async, rst=1):
  - All countdowns and counters go to 0; busy = 0.
  - issue_top = 0, issue_bot = 0, stall = 0, rf_we_top = 0, rf_we_bot = 0, held while rst = 1.
- Hazards: a source or destination hazards only when it is nonzero and busy. Register 0 is never busy and never hazards.
- issue_top (combinational) = !rst & !flush & top_valid & none of top_rs1, top_rs2, top_rd (if top_wr) busy.
- issue_bot = issue_top & bot_valid, plus all of the following:
  - bot sources and destination not busy.
  - Intra-pair RAW: if top_wr & top_rd != 0, neither bot_rs1 nor bot_rs2 equals top_rd.
  - Intra-pair WAW: if both write, bot_rd != top_rd (unless both are 0).
  - Bot never issues without top (in-order).
- Scoreboard update (posedge clk), for each register r != 0:
  - Load: an issuing slot with wr, rd = r and lat > 0 loads count[r] = lat.
  - Decrement: otherwise, if count[r] > 0, count[r] decrements by 1.
  - busy[r] = (count[r] != 0).
  - A load and a decrement on the same register cannot coincide, because issue is blocked while busy. The load takes priority regardless.
  - A load with lat = 1 gives busy for exactly 1 cycle after issue.
- Write-port collision:
  - rf_we_bot = wb_we_bot & !rst.
  - rf_we_top = wb_we_top & !rst & !(wb_we_bot & wb_wa_bot == wb_wa_top). The younger (bot) write wins.
  - Combinational, no latency.
- Counters (posedge clk, wrap modulo 2^CNT_W):
  - dual_cnt += 1 when issue_top & issue_bot.
  - single_cnt += 1 when issue_top & !issue_bot.
  - stall_cnt += 1 when stall.
- flush:
  - Suppresses issue and does not count as stall.
  - Existing countdowns keep running, because in-flight writes still complete.
- Reset mid-operation: all pending countdowns are cleared immediately, and issue is permitted from the first clock after rst deasserts.

Decomposition:
- Shared package:
  - NREG, AW, LAT_W constants.
  - Issue-slot struct typedef {valid, rs1, rs2, rd, wr, lat}.
  - Function hazard(addr, busy) returning (addr != 0) & busy[addr].
- One sub-module: sb_counter, a single per-register LAT_W countdown with load/decrement and busy output, instantiated NREG-1 times (r = 1..31).

Test Plan:
- Reset: assert rst mid-run with busy[5] = 1 and dual_cnt = 7 -> busy = 0, counters = 0, all issue/we outputs 0 immediately.
- Independent pair: top add r1 <- r2,r3 (lat 0), bot add r4 <- r5,r6 -> issue_top = issue_bot = 1, dual_cnt increments 0 -> 1.
- Intra-pair RAW: top r7 <- r1,r2, bot r8 <- r7,r3 -> issue_top = 1, issue_bot = 0, single_cnt = 1. Destination r0 (top_rd = 0) does not block a bot that reads r0.
- Load latency: top lw r9 with lat = 3 issues at cycle 0; next top reads r9:
  - Stall at cycles 1-3 (stall_cnt = 3), busy[9] = 1.
  - Issue at cycle 4, busy[9] = 0.
- Write collision: wb_we_top = wb_we_bot = 1, both addresses 12 -> rf_we_top = 0, rf_we_bot = 1. With addresses 12 and 13 -> both 1.
- Flush: busy[4] count = 2, flush = 1 with valid independent pair -> no issue, stall = 0, stall_cnt unchanged, busy[4] still clears 2 cycles later.
